// File: rtl/softmax_norm.sv
// Softmax normalisation stage: buffers a group of clamped e^x scores, sums them,
// then emits each score divided by the group sum as an unsigned Q0.8 weight.
module softmax_norm #(
  parameter int N_SCORES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] s_data,
  input  logic       s_vld,
  output logic       s_rdy,
  output logic [7:0] m_data,
  output logic       m_vld,
  input  logic       m_rdy,
  output logic       m_last,
  output logic       busy
);

  localparam int IDX_W = $clog2(N_SCORES);
  localparam int SUM_W = 7 + IDX_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SCORES - 1);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    DIVIDE  = 2'd1,
    OUTPUT  = 2'd2
  } state_t;

  state_t           state;
  logic [6:0]       score_buf [N_SCORES];
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] rd_idx;
  logic [SUM_W-1:0] sum;
  logic [SUM_W-1:0] rem;
  logic [8:0]       quo;
  logic [3:0]       cnt;

  logic [6:0]       clamped;
  logic [6:0]       cur;
  logic [SUM_W:0]   trial;
  logic             ge;
  logic [SUM_W-1:0] rem_next;
  logic [8:0]       quo_next;
  logic [7:0]       result;

  assign s_rdy = (state == COLLECT);
  assign m_vld = (state == OUTPUT);
  assign busy  = (state != COLLECT);

  // Input clamp and one restoring-division step; quo doubles as the dividend
  // low-bit shifter, so after nine steps it holds the 9-bit quotient.
  always_comb begin
    clamped  = 7'd0;
    rem_next = rem;
    result   = 8'd0;
    if (s_data[7]) begin
      clamped = 7'd0;
    end else begin
      clamped = s_data[6:0];
    end
    cur   = score_buf[rd_idx];
    trial = {rem, quo[8]};
    ge    = (trial >= {1'b0, sum});
    if (ge) begin
      rem_next = trial[SUM_W-1:0] - sum;
    end else begin
      rem_next = trial[SUM_W-1:0];
    end
    quo_next = {quo[7:0], ge};
    if (sum == {SUM_W{1'b0}}) begin
      result = 8'd0;
    end else if (quo_next[8]) begin
      result = 8'hFF;
    end else begin
      result = quo_next[7:0];
    end
  end

  // Score buffer write; contents need no reset.
  always_ff @(posedge clk) begin
    if (s_rdy && s_vld) begin
      score_buf[wr_idx] <= clamped;
    end
  end

  // Control FSM with accumulator, divider registers and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= COLLECT;
      sum    <= {SUM_W{1'b0}};
      wr_idx <= {IDX_W{1'b0}};
      rd_idx <= {IDX_W{1'b0}};
      rem    <= {SUM_W{1'b0}};
      quo    <= 9'd0;
      cnt    <= 4'd0;
      m_data <= 8'd0;
      m_last <= 1'b0;
    end else begin
      case (state)
        COLLECT: begin
          if (s_vld) begin
            sum    <= sum + {{IDX_W{1'b0}}, clamped};
            wr_idx <= wr_idx + IDX_W'(1);
            if (wr_idx == LAST_IDX) begin
              state  <= DIVIDE;
              rd_idx <= {IDX_W{1'b0}};
              cnt    <= 4'd0;
            end
          end
        end
        DIVIDE: begin
          if (cnt == 4'd0) begin
            // Initial partial remainder is score>>1, always below a nonzero sum.
            rem <= {{(SUM_W-6){1'b0}}, cur[6:1]};
            quo <= {cur[0], 8'h00};
            cnt <= 4'd1;
          end else begin
            if (sum != {SUM_W{1'b0}}) begin
              rem <= rem_next;
              quo <= quo_next;
            end
            if (cnt == 4'd9) begin
              m_data <= result;
              m_last <= (rd_idx == LAST_IDX);
              state  <= OUTPUT;
            end else begin
              cnt <= cnt + 4'd1;
            end
          end
        end
        OUTPUT: begin
          if (m_rdy) begin
            m_last <= 1'b0;
            if (rd_idx == LAST_IDX) begin
              sum    <= {SUM_W{1'b0}};
              wr_idx <= {IDX_W{1'b0}};
              rd_idx <= {IDX_W{1'b0}};
              state  <= COLLECT;
            end else begin
              rd_idx <= rd_idx + IDX_W'(1);
              cnt    <= 4'd0;
              state  <= DIVIDE;
            end
          end
        end
        default: begin
          state <= COLLECT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_softmax_norm.sv
// Directed self-checking bench for softmax_norm with hand-computed weights.
module tb_softmax_norm;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] s_data = 8'd0;
  logic       s_vld = 1'b0;
  logic       s_rdy;
  logic [7:0] m_data;
  logic       m_vld;
  logic       m_rdy = 1'b0;
  logic       m_last;
  logic       busy;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int last_hs = 0;
  logic [7:0] got_d [4];
  logic       got_l [4];
  int         got_lat [4];

  softmax_norm #(.N_SCORES(4)) dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_vld(s_vld), .s_rdy(s_rdy),
    .m_data(m_data), .m_vld(m_vld), .m_rdy(m_rdy), .m_last(m_last), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic send(input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] c, input logic [7:0] d);
    logic [7:0] v [4];
    v = '{a, b, c, d};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      s_data = v[i];
      s_vld  = 1'b1;
      @(posedge clk);
    end
    @(negedge clk);
    s_vld   = 1'b0;
    last_hs = cyc;
  endtask

  task automatic recv(input int n);
    int w;
    m_rdy = 1'b1;
    for (int k = 0; k < n; k++) begin
      w = 0;
      do begin
        @(negedge clk);
        w++;
      end while (!m_vld && w < 40);
      got_lat[k] = m_vld ? (cyc - last_hs) : -1;
      got_d[k]   = m_data;
      got_l[k]   = m_last;
      last_hs    = cyc + 1;
    end
    @(negedge clk);
    m_rdy = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    n_checks++;
    if ({s_rdy, m_vld, m_last, busy, m_data} !== {4'b1000, 8'h00}) begin
      n_fail++;
      $display("FAIL reset_outputs: got rdy=%b vld=%b last=%b busy=%b data=%h expected 1 0 0 0 00",
               s_rdy, m_vld, m_last, busy, m_data);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({s_rdy, m_vld, busy} !== 3'b100) begin
      n_fail++;
      $display("FAIL post_reset_idle: got rdy=%b vld=%b busy=%b expected 1 0 0", s_rdy, m_vld, busy);
    end
  endtask

  task automatic test_uniform();
    send(8'd64, 8'd64, 8'd64, 8'd64);
    n_checks++;
    if ({s_rdy, busy} !== 2'b01) begin
      n_fail++;
      $display("FAIL divide_flags: got rdy=%b busy=%b expected 0 1", s_rdy, busy);
    end
    recv(4);
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (got_d[k] !== 8'h40 || got_l[k] !== (k == 3) || got_lat[k] !== 10) begin
        n_fail++;
        $display("FAIL uniform[%0d]: got data=%h last=%b lat=%0d expected 40 %b 10",
                 k, got_d[k], got_l[k], got_lat[k], (k == 3));
      end
    end
  endtask

  task automatic test_ratio();
    logic [7:0] exp_d [4];
    exp_d = '{8'd25, 8'd51, 8'd76, 8'd102};
    send(8'd10, 8'd20, 8'd30, 8'd40);
    recv(4);
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (got_d[k] !== exp_d[k] || got_l[k] !== (k == 3) || got_lat[k] !== 10) begin
        n_fail++;
        $display("FAIL ratio[%0d]: got data=%0d last=%b lat=%0d expected %0d %b 10",
                 k, got_d[k], got_l[k], got_lat[k], exp_d[k], (k == 3));
      end
    end
  endtask

  task automatic test_saturate();
    logic [7:0] exp_d [4];
    exp_d = '{8'd255, 8'd0, 8'd0, 8'd0};
    send(8'd64, 8'd0, 8'd0, 8'd0);
    recv(4);
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (got_d[k] !== exp_d[k] || got_lat[k] !== 10) begin
        n_fail++;
        $display("FAIL saturate[%0d]: got data=%0d lat=%0d expected %0d 10",
                 k, got_d[k], got_lat[k], exp_d[k]);
      end
    end
  endtask

  task automatic test_clamp_zero_sum();
    send(8'h80, 8'hFF, 8'h00, 8'h00);
    recv(4);
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (got_d[k] !== 8'd0 || got_l[k] !== (k == 3) || got_lat[k] !== 10) begin
        n_fail++;
        $display("FAIL zero_sum[%0d]: got data=%0d last=%b lat=%0d expected 0 %b 10",
                 k, got_d[k], got_l[k], got_lat[k], (k == 3));
      end
    end
  endtask

  task automatic test_backpressure();
    int w;
    send(8'd10, 8'd20, 8'd30, 8'd40);
    recv(1);
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!m_vld && w < 40);
    n_checks++;
    if (got_d[0] !== 8'd25 || (cyc - last_hs) !== 10) begin
      n_fail++;
      $display("FAIL bp_first: got data=%0d lat=%0d expected 25 10", got_d[0], cyc - last_hs);
    end
    for (int i = 0; i < 20; i++) begin
      n_checks++;
      if ({m_vld, m_last, s_rdy} !== 3'b100 || m_data !== 8'd51) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: got vld=%b last=%b rdy=%b data=%0d expected 1 0 0 51",
                 i, m_vld, m_last, s_rdy, m_data);
      end
      s_data = 8'h7F;
      s_vld  = (i % 2 == 0);
      @(negedge clk);
    end
    s_vld   = 1'b0;
    m_rdy   = 1'b1;
    last_hs = cyc + 1;
    recv(2);
    n_checks++;
    if (got_d[0] !== 8'd76 || got_d[1] !== 8'd102 || got_l[1] !== 1'b1 || got_lat[0] !== 10) begin
      n_fail++;
      $display("FAIL bp_tail: got %0d %0d last=%b lat=%0d expected 76 102 1 10",
               got_d[0], got_d[1], got_l[1], got_lat[0]);
    end
    n_checks++;
    if ({s_rdy, busy} !== 2'b10) begin
      n_fail++;
      $display("FAIL bp_idle: got rdy=%b busy=%b expected 1 0", s_rdy, busy);
    end
  endtask

  task automatic test_async_reset();
    int w;
    send(8'd10, 8'd20, 8'd30, 8'd40);
    recv(2);
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!m_vld && w < 40);
    n_checks++;
    if (m_vld !== 1'b1 || m_data !== 8'd76) begin
      n_fail++;
      $display("FAIL ar_pre: got vld=%b data=%0d expected 1 76", m_vld, m_data);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({s_rdy, m_vld, m_last, busy, m_data} !== {4'b1000, 8'h00}) begin
      n_fail++;
      $display("FAIL ar_immediate: got rdy=%b vld=%b last=%b busy=%b data=%h expected 1 0 0 0 00",
               s_rdy, m_vld, m_last, busy, m_data);
    end
    @(negedge clk);
    rst = 1'b0;
    send(8'd32, 8'd32, 8'd32, 8'd32);
    recv(4);
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (got_d[k] !== 8'h40 || got_l[k] !== (k == 3) || got_lat[k] !== 10) begin
        n_fail++;
        $display("FAIL ar_fresh[%0d]: got data=%h last=%b lat=%0d expected 40 %b 10",
                 k, got_d[k], got_l[k], got_lat[k], (k == 3));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] g2 [4];
    logic [7:0] exp_d [8];
    logic [7:0] out_d [8];
    logic       out_l [8];
    int in_cnt, out_cnt, first_acc, g1_end;
    g2    = '{8'd40, 8'd30, 8'd20, 8'd10};
    exp_d = '{8'd25, 8'd51, 8'd76, 8'd102, 8'd102, 8'd76, 8'd51, 8'd25};
    send(8'd10, 8'd20, 8'd30, 8'd40);
    in_cnt = 0; out_cnt = 0; first_acc = -1; g1_end = -2;
    s_data = g2[0];
    s_vld  = 1'b1;
    m_rdy  = 1'b1;
    for (int t = 0; t < 300 && out_cnt < 8; t++) begin
      @(negedge clk);
      if (in_cnt < 4) s_data = g2[in_cnt];
      else s_vld = 1'b0;
      if (m_vld) begin
        out_d[out_cnt] = m_data;
        out_l[out_cnt] = m_last;
        if (out_cnt == 3) g1_end = cyc + 1;
        out_cnt++;
      end
      if (s_vld && s_rdy) begin
        if (in_cnt == 0) first_acc = cyc + 1;
        in_cnt++;
      end
    end
    m_rdy = 1'b0;
    s_vld = 1'b0;
    n_checks++;
    if (out_cnt !== 8 || first_acc !== g1_end + 1) begin
      n_fail++;
      $display("FAIL b2b_timing: got outputs=%0d first_accept=%0d expected 8 %0d",
               out_cnt, first_acc, g1_end + 1);
    end
    for (int k = 0; k < 8; k++) begin
      n_checks++;
      if (k >= out_cnt || out_d[k] !== exp_d[k] || out_l[k] !== (k % 4 == 3)) begin
        n_fail++;
        $display("FAIL b2b[%0d]: got data=%0d last=%b expected %0d %b",
                 k, out_d[k], out_l[k], exp_d[k], (k % 4 == 3));
      end
    end
  endtask

  initial begin
    test_reset();
    test_uniform();
    test_ratio();
    test_saturate();
    test_clamp_zero_sum();
    test_backpressure();
    test_async_reset();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/softmax_norm.md
# softmax_norm

Softmax normalisation stage placed directly downstream of the attention MAC / e^x stage. It collects a group of N_SCORES exponentiated scores over a valid/ready slave port and buffers them while summing. It then divides each buffered score by the group sum with a sequential restoring divider and streams the normalised weights out over a valid/ready master port, with a last-flag on the final weight of the group.

## Interface
- N_SCORES, 4: scores per softmax group; must be a power of two, minimum 2.
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  reset, asynchronous and active-high.
- s_data  input  8  exponentiated score, Q1.6 two's complement, as produced by the e^x stage.
- s_vld  input  1  s_data valid.
- s_rdy  output  1  stage can accept s_data.
- m_data  output  8  normalised weight, unsigned Q0.8.
- m_vld  output  1  m_data valid.
- m_rdy  input  1  downstream accepts m_data.
- m_last  output  1  qualifies the final weight of a group; meaningful only while m_vld=1.
- busy  output  1  high in every state except COLLECT.

## Operation
- A handshake occurs on a rising edge where vld=1 and rdy=1; with any other combination, no transfer occurs on that edge.
- **Input clamp:** if s_data[7]=1 (negative), the stored value is 0; otherwise the stored value is s_data[6:0].
  - Stored scores are 7-bit unsigned; the buffer holds N_SCORES entries.
- **Sum register:** width 7+log2(N_SCORES) bits (9 bits at the default). It never overflows.
- **State machine:** COLLECT, DIVIDE, OUTPUT.
- **COLLECT**
  - s_rdy=1, m_vld=0.
  - Each input handshake writes buf[wr_idx], adds the clamped value to sum and increments wr_idx.
  - On the handshake with wr_idx=N_SCORES-1: go to DIVIDE, rd_idx=0.
- **DIVIDE**
  - s_rdy=0, m_vld=0.
  - Computes q = floor(buf[rd_idx]*256 / sum) with a 9-iteration restoring division, one quotient bit per cycle.
  - If q ≥ 256 (only possible when buf[rd_idx] equals sum), the result saturates to 255.
  - If sum = 0, the result is 0 and no division is performed; latency is unchanged.
  - When the result is complete: register it on m_data, go to OUTPUT.
- **OUTPUT**
  - s_rdy=0, m_vld=1, m_last=(rd_idx==N_SCORES-1).
  - m_data and m_last are held stable until the output handshake.
  - On the output handshake:
    - If not last: rd_idx+1, go to DIVIDE.
    - If last: clear sum, wr_idx and rd_idx, go to COLLECT.
- Weights of a group are emitted in arrival order.
- Rounding is truncation. The weights of a group may sum to less than 256 LSB.
- **Reset** (asserted at any time, including mid-group) immediately forces:
  - state=COLLECT;
  - sum, wr_idx, rd_idx, m_data, and the division registers cleared;
  - a partial group is discarded.
- Output values while rst=1: s_rdy=1, m_vld=0, m_last=0, m_data=0, busy=0.
- The buffer contents need no reset.

## Timing
- s_rdy, m_vld, m_last and busy are decoded from registered state only; there is no combinational path from s_vld or m_rdy to any output.
- Throughput in COLLECT: one score per cycle.
- Latency from the Nth input handshake edge to m_vld=1: exactly 10 rising edges. m_vld is visible in the cycle following the 10th edge.
- Latency from a non-last output handshake edge to the next m_vld=1: exactly 10 rising edges.
- s_rdy rises in the cycle after the last output handshake. An input may be accepted on the next edge, with no dead cycle beyond that.
- Back-pressure: m_rdy held low keeps m_vld=1 and m_data unchanged indefinitely.
- s_vld asserted during DIVIDE or OUTPUT is ignored; the upstream stage holds its data.
- Minimum group period at default N: 4 + 4×10 + 4 output cycles.

## Test plan
- Inputs 64,64,64,64 (1.0 each), m_rdy=1 → four outputs 0x40, m_last only on the 4th; first m_vld appears 10 edges after the 4th accept.
- Inputs 10,20,30,40 → sum 100; outputs 25, 51, 76, 102 in order.
- Inputs 64,0,0,0 → outputs 255 (saturated), 0, 0, 0. Inputs 0x80,0xFF,0,0 (negative, clamped) → sum 0; outputs 0,0,0,0 with unchanged latency.
- Back-pressure: m_rdy=0 for 20 cycles on the 2nd weight → m_data stable and m_vld high throughout; s_vld pulses during this window are not accepted (s_rdy=0).
- Reset asserted asynchronously mid-OUTPUT after 2 weights → m_vld drops immediately, s_rdy=1. A following fresh group of 32,32,32,32 yields 0x40 ×4 with no residue from the aborted group.
- Back-to-back groups with s_vld held high: the first input of group 2 is accepted on the edge after group 1's final handshake; group 2's weights are correct.
